// File: rtl/addr_dec_pe_req_ot.sv
// Per-PE request router: decodes the target from the address, limits outstanding
// requests, and stalls on a target change until every earlier response has returned.
module addr_dec_pe_req_ot #(
    parameter int          ID_WIDTH           = 17,
    parameter int          ID                 = 1,
    parameter int          N_SLAVE            = 16,
    parameter int          LOG_CLUSTER        = 5,
    parameter int          ADDR_WIDTH         = 32,
    parameter int          PE_ROUTING_LSB     = 16,
    parameter int          PE_ROUTING_MSB     = 19,
    parameter logic [11:0] PE_BASE            = 12'h100,
    parameter int          CLUSTER_ALIAS      = 0,
    parameter logic [11:0] CLUSTER_ALIAS_BASE = 12'h000,
    parameter int          MAX_OUTSTANDING    = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [LOG_CLUSTER-1:0]                 CLUSTER_ID,
    input  logic                                   data_req_i,
    input  logic [ADDR_WIDTH-1:0]                  data_add_i,
    output logic                                   data_gnt_o,
    input  logic                                   data_r_valid_i,
    input  logic [N_SLAVE-1:0]                     data_gnt_i,
    output logic [N_SLAVE-1:0]                     data_req_o,
    output logic [ID_WIDTH-1:0]                    data_ID_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   resp_err_o
);

    localparam int TW = $clog2(N_SLAVE);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW = PE_ROUTING_MSB - PE_ROUTING_LSB + 1;
    localparam logic [TW-1:0] DEFAULT_TGT = TW'(N_SLAVE - 1);

    logic [CW-1:0]  r_cnt;
    logic [TW-1:0]  r_last_tgt;
    logic           r_resp_err;

    logic [11:0]    w_pe_start;
    logic [11:0]    w_top;
    logic [FW-1:0]  w_field;
    logic           w_in_win;
    logic           w_field_ok;
    logic [TW-1:0]  w_tgt;
    logic           w_stall;
    logic           w_accept;
    logic           w_unused;

    assign w_pe_start = PE_BASE + 12'({CLUSTER_ID, 2'b00}) + 12'd2;
    assign w_top      = data_add_i[31:20];
    assign w_field    = data_add_i[PE_ROUTING_MSB:PE_ROUTING_LSB];
    assign w_in_win   = (w_top == w_pe_start) ||
                        ((CLUSTER_ALIAS != 0) && (w_top == CLUSTER_ALIAS_BASE + 12'd2));
    assign w_field_ok = 32'(w_field) < 32'(N_SLAVE - 1);
    assign w_tgt      = (w_in_win && w_field_ok) ? TW'(w_field) : DEFAULT_TGT;
    assign w_unused   = ^data_add_i;

    // A target change waits for the count to drain so responses stay in order.
    assign w_stall  = (r_cnt == CW'(MAX_OUTSTANDING)) ||
                      ((r_cnt != '0) && (w_tgt != r_last_tgt));
    assign w_accept = data_req_i && !w_stall && data_gnt_i[w_tgt];

    always_comb begin
        data_req_o = '0;
        data_gnt_o = 1'b0;
        if (!w_stall) begin
            data_req_o[w_tgt] = data_req_i;
            data_gnt_o        = data_gnt_i[w_tgt];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_last_tgt <= DEFAULT_TGT;
            r_resp_err <= 1'b0;
        end else begin
            if (w_accept)
                r_last_tgt <= w_tgt;
            if (w_accept && !data_r_valid_i) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (!w_accept && data_r_valid_i) begin
                if (r_cnt != '0)
                    r_cnt <= r_cnt - CW'(1);
                else
                    r_resp_err <= 1'b1;
            end
        end
    end

    assign data_ID_o     = ID_WIDTH'(ID);
    assign outstanding_o = r_cnt;
    assign resp_err_o    = r_resp_err;

endmodule
